// File: rtl/snake_pkg.sv
// Shared encodings for the snake game sequencer: directions, game states
// and the default move period.
package snake_pkg;

    // Keyboard / datapath direction encoding
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    // Game-level states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } game_state_t;

    // Frames between moves at the start of a game
    localparam int DEFAULT_FRAMES_PER_MOVE = 6;

    // Opposite heading: flipping bit 1 turns up<->down and right<->left
    function automatic logic [1:0] opposite_dir(input logic [1:0] dir);
        return dir ^ 2'd2;
    endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score counter with synchronous clear, increment and
// saturation at 99.
module bcd_score_counter (
    input  logic       VGA_clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       inc,
    output logic [3:0] ones,
    output logic [3:0] tens
);

    logic [3:0] ones_reg;
    logic [3:0] tens_reg;
    logic       at_max;

    assign at_max = (tens_reg == 4'd9) && (ones_reg == 4'd9);

    // Score digits: clear wins over increment, increment stops at 99
    always_ff @(posedge VGA_clk) begin
        if (!reset_n || clear) begin
            ones_reg <= 4'd0;
            tens_reg <= 4'd0;
        end else if (inc && !at_max) begin
            if (ones_reg == 4'd9) begin
                ones_reg <= 4'd0;
                tens_reg <= tens_reg + 4'd1;
            end else begin
                ones_reg <= ones_reg + 4'd1;
            end
        end
    end

    assign ones = ones_reg;
    assign tens = tens_reg;

endmodule

// File: rtl/snake_game_sequencer.sv
// Game-level sequencer for the snake datapath: IDLE/RUN/OVER state machine,
// frame divider producing the move strobe, direction arbiter rejecting
// reversals, grow tracking and speed-up as apples are eaten.
module snake_game_sequencer
    import snake_pkg::*;
#(
    parameter int FRAMES_PER_MOVE = DEFAULT_FRAMES_PER_MOVE,
    parameter int MIN_FRAMES      = 2,
    parameter int SPEEDUP_EVERY   = 5
) (
    input  logic       VGA_clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       frame_tick,
    input  logic       dir_valid,
    input  logic [1:0] dir_req,
    input  logic       collision,
    input  logic       apple_eaten,
    output logic       move_tick,
    output logic [1:0] direction,
    output logic       grow,
    output logic       game_over,
    output logic       running,
    output logic [3:0] score_ones,
    output logic [3:0] score_tens
);

    localparam int PW  = $clog2(FRAMES_PER_MOVE + 1);
    localparam int ACW = $clog2(SPEEDUP_EVERY + 1);

    game_state_t    state_reg, state_next;
    logic           start_q_reg;
    logic [PW-1:0]  frame_cnt_reg, frame_cnt_next;
    logic [PW-1:0]  period_reg, period_next;
    logic [ACW-1:0] apple_cnt_reg, apple_cnt_next;
    logic [1:0]     direction_reg, direction_next;
    logic [1:0]     pending_reg, pending_next;
    logic           grow_pending_reg, grow_pending_next;
    logic           move_tick_reg, move_tick_next;
    logic           grow_reg, grow_next;
    logic           running_reg, running_next;
    logic           game_over_reg, game_over_next;
    logic           score_clear;
    logic           score_inc;
    logic           start_edge;

    assign start_edge = start && !start_q_reg;

    // Next-state, divider, arbiter and score control for the current state
    always_comb begin
        state_next        = state_reg;
        frame_cnt_next    = frame_cnt_reg;
        period_next       = period_reg;
        apple_cnt_next    = apple_cnt_reg;
        direction_next    = direction_reg;
        pending_next      = pending_reg;
        grow_pending_next = grow_pending_reg;
        move_tick_next    = 1'b0;
        grow_next         = 1'b0;
        score_clear       = 1'b0;
        score_inc         = 1'b0;

        case (state_reg)
            ST_RUN: begin
                if (collision) begin
                    // Collision freezes everything, even a coincident apple or frame
                    state_next = ST_OVER;
                end else begin
                    // Checked against the committed heading, so a request in
                    // the move cycle is judged against the outgoing direction
                    if (dir_valid && (dir_req != opposite_dir(direction_reg))) begin
                        pending_next = dir_req;
                    end
                    if (frame_tick) begin
                        // >= covers a period that shrank below the running count
                        if (frame_cnt_reg >= period_reg - 1'b1) begin
                            frame_cnt_next    = '0;
                            move_tick_next    = 1'b1;
                            direction_next    = pending_reg;
                            grow_next         = grow_pending_reg;
                            grow_pending_next = 1'b0;
                        end else begin
                            frame_cnt_next = frame_cnt_reg + 1'b1;
                        end
                    end
                    if (apple_eaten) begin
                        score_inc         = 1'b1;
                        grow_pending_next = 1'b1;
                        if (apple_cnt_reg == ACW'(SPEEDUP_EVERY - 1)) begin
                            apple_cnt_next = '0;
                            if (period_reg > PW'(MIN_FRAMES)) begin
                                period_next = period_reg - 1'b1;
                            end
                        end else begin
                            apple_cnt_next = apple_cnt_reg + 1'b1;
                        end
                    end
                end
            end
            default: begin
                // IDLE and OVER both wait for a start press to open a new game
                if (start_edge) begin
                    state_next        = ST_RUN;
                    frame_cnt_next    = '0;
                    period_next       = PW'(FRAMES_PER_MOVE);
                    apple_cnt_next    = '0;
                    direction_next    = DIR_RIGHT;
                    pending_next      = DIR_RIGHT;
                    grow_pending_next = 1'b0;
                    score_clear       = 1'b1;
                end
            end
        endcase

        running_next   = (state_next == ST_RUN);
        game_over_next = (state_next == ST_OVER);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge VGA_clk) begin
        if (!reset_n) begin
            state_reg        <= ST_IDLE;
            start_q_reg      <= 1'b0;
            frame_cnt_reg    <= '0;
            period_reg       <= PW'(FRAMES_PER_MOVE);
            apple_cnt_reg    <= '0;
            direction_reg    <= DIR_RIGHT;
            pending_reg      <= DIR_RIGHT;
            grow_pending_reg <= 1'b0;
            move_tick_reg    <= 1'b0;
            grow_reg         <= 1'b0;
            running_reg      <= 1'b0;
            game_over_reg    <= 1'b0;
        end else begin
            state_reg        <= state_next;
            start_q_reg      <= start;
            frame_cnt_reg    <= frame_cnt_next;
            period_reg       <= period_next;
            apple_cnt_reg    <= apple_cnt_next;
            direction_reg    <= direction_next;
            pending_reg      <= pending_next;
            grow_pending_reg <= grow_pending_next;
            move_tick_reg    <= move_tick_next;
            grow_reg         <= grow_next;
            running_reg      <= running_next;
            game_over_reg    <= game_over_next;
        end
    end

    bcd_score_counter u_score (
        .VGA_clk (VGA_clk),
        .reset_n (reset_n),
        .clear   (score_clear),
        .inc     (score_inc),
        .ones    (score_ones),
        .tens    (score_tens)
    );

    assign move_tick = move_tick_reg;
    assign direction = direction_reg;
    assign grow      = grow_reg;
    assign running   = running_reg;
    assign game_over = game_over_reg;

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Self-checking bench for snake_game_sequencer: directed game scenarios
// followed by random play, every cycle compared against a game-rule model.
module tb_snake_game_sequencer;
    import snake_pkg::*;

    localparam int FPM = 6;
    localparam int MINF = 2;
    localparam int SPD = 5;

    logic       VGA_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       frame_tick = 1'b0;
    logic       dir_valid = 1'b0;
    logic [1:0] dir_req = 2'd0;
    logic       collision = 1'b0;
    logic       apple_eaten = 1'b0;
    logic       move_tick;
    logic [1:0] direction;
    logic       grow;
    logic       game_over;
    logic       running;
    logic [3:0] score_ones;
    logic [3:0] score_tens;

    int passed_cnt = 0;
    int total_cnt = 0;
    int fail_cnt = 0;

    // Reference model state, expressed as game rules
    bit m_run = 0, m_over = 0, m_growp = 0, prev_start = 0;
    int m_score = 0, m_apples = 0, m_frames = 0, m_dir = 1, m_pend = 1;
    bit exp_move = 0, exp_grow = 0;

    snake_game_sequencer #(
        .FRAMES_PER_MOVE (FPM),
        .MIN_FRAMES      (MINF),
        .SPEEDUP_EVERY   (SPD)
    ) dut (
        .VGA_clk     (VGA_clk),
        .reset_n     (reset_n),
        .start       (start),
        .frame_tick  (frame_tick),
        .dir_valid   (dir_valid),
        .dir_req     (dir_req),
        .collision   (collision),
        .apple_eaten (apple_eaten),
        .move_tick   (move_tick),
        .direction   (direction),
        .grow        (grow),
        .game_over   (game_over),
        .running     (running),
        .score_ones  (score_ones),
        .score_tens  (score_tens)
    );

    always #5 VGA_clk = ~VGA_clk;

    function automatic int cur_period();
        int p = FPM - m_apples / SPD;
        return (p < MINF) ? MINF : p;
    endfunction

    // Advance the model by one clock given the inputs currently driven
    task automatic model_step();
        bit st_edge;
        st_edge = start && !prev_start;
        exp_move = 0;
        exp_grow = 0;
        if (!reset_n) begin
            m_run = 0; m_over = 0; m_growp = 0; prev_start = 0;
            m_score = 0; m_apples = 0; m_frames = 0; m_dir = 1; m_pend = 1;
            return;
        end
        prev_start = start;
        if (m_run) begin
            if (collision) begin
                m_run = 0;
                m_over = 1;
            end else begin
                int new_dir;
                new_dir = m_dir;
                if (frame_tick) begin
                    m_frames++;
                    if (m_frames >= cur_period()) begin
                        m_frames = 0;
                        exp_move = 1;
                        exp_grow = m_growp;
                        m_growp = 0;
                        new_dir = m_pend;
                    end
                end
                if (dir_valid && int'(dir_req) != (m_dir + 2) % 4) m_pend = dir_req;
                m_dir = new_dir;
                if (apple_eaten) begin
                    if (m_score < 99) m_score++;
                    m_apples++;
                    m_growp = 1;
                end
            end
        end else if (st_edge) begin
            m_run = 1; m_over = 0; m_growp = 0;
            m_score = 0; m_apples = 0; m_frames = 0; m_dir = 1; m_pend = 1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) passed_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic [7:0] exp_score;
        exp_score = {4'(m_score / 10), 4'(m_score % 10)};
        check("move_tick", {7'd0, move_tick}, {7'd0, exp_move});
        check("grow", {7'd0, grow}, {7'd0, exp_grow});
        check("direction", {6'd0, direction}, 8'(m_dir));
        check("running", {7'd0, running}, {7'd0, m_run});
        check("game_over", {7'd0, game_over}, {7'd0, m_over});
        check("score", {score_tens, score_ones}, exp_score);
    endtask

    // One clock: update the model, let the DUT clock, compare, drop pulses
    task automatic tick();
        model_step();
        @(posedge VGA_clk);
        #1;
        compare_all();
        frame_tick = 0;
        dir_valid = 0;
        apple_eaten = 0;
        collision = 0;
    endtask

    task automatic press_start();
        start = 1; tick();
        start = 0; tick();
    endtask

    task automatic eat_apple();
        apple_eaten = 1; tick();
        tick();
    endtask

    initial begin
        // Reset state
        reset_n = 0;
        repeat (3) tick();
        check("reset_dir", {6'd0, direction}, {6'd0, DIR_RIGHT});
        check("reset_score", {score_tens, score_ones}, 8'h00);
        reset_n = 1;
        tick();

        // Start, then the first move on the 6th frame tick
        start = 1; tick();
        check("start_running", {7'd0, running}, 8'd1);
        start = 0; tick();
        for (int i = 0; i < FPM - 1; i++) begin
            frame_tick = 1; tick();
            tick(); tick();
        end
        frame_tick = 1; tick();
        check("first_move", {7'd0, move_tick}, 8'd1);
        check("first_move_dir", {6'd0, direction}, {6'd0, DIR_RIGHT});
        tick();

        // Reversal to left rejected, up accepted at the next move
        dir_valid = 1; dir_req = DIR_LEFT; tick();
        dir_valid = 1; dir_req = DIR_UP; tick();
        for (int i = 0; i < FPM - 1; i++) begin
            frame_tick = 1; tick();
            tick();
        end
        frame_tick = 1; tick();
        check("turn_move", {7'd0, move_tick}, 8'd1);
        check("turn_dir", {6'd0, direction}, {6'd0, DIR_UP});
        tick();

        // Ten apples: score 10, period shrinks to 4, grow on next move
        for (int i = 0; i < 10; i++) eat_apple();
        check("score_10", {score_tens, score_ones}, 8'h10);
        for (int i = 0; i < 3; i++) begin
            frame_tick = 1; tick();
            tick();
        end
        frame_tick = 1; tick();
        check("fast_move", {7'd0, move_tick}, 8'd1);
        check("fast_grow", {7'd0, grow}, 8'd1);
        tick();

        // Saturate at 99
        for (int i = 0; i < 89; i++) eat_apple();
        check("score_99", {score_tens, score_ones}, 8'h99);
        eat_apple();
        check("score_sat", {score_tens, score_ones}, 8'h99);

        // Collision with apple: over, score unchanged, no further moves
        collision = 1; apple_eaten = 1; tick();
        check("over_flag", {7'd0, game_over}, 8'd1);
        check("over_score", {score_tens, score_ones}, 8'h99);
        for (int i = 0; i < 10; i++) begin
            frame_tick = 1; tick();
        end

        // Restart from OVER
        start = 1; tick();
        check("restart_run", {7'd0, running}, 8'd1);
        check("restart_score", {score_tens, score_ones}, 8'h00);
        check("restart_dir", {6'd0, direction}, {6'd0, DIR_RIGHT});
        start = 0; tick();

        // Reset mid-game with grow pending: no grow after the new start
        eat_apple();
        reset_n = 0; tick();
        check("midreset_run", {7'd0, running}, 8'd0);
        check("midreset_score", {score_tens, score_ones}, 8'h00);
        reset_n = 1; tick();
        press_start();
        for (int i = 0; i < FPM - 1; i++) begin
            frame_tick = 1; tick();
        end
        frame_tick = 1; tick();
        check("post_reset_move", {7'd0, move_tick}, 8'd1);
        check("post_reset_grow", {7'd0, grow}, 8'd0);
        tick();

        // Random play
        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 29) == 0) start = !start;
            frame_tick = ($urandom_range(0, 2) == 0);
            dir_valid = ($urandom_range(0, 3) == 0);
            dir_req = 2'($urandom_range(0, 3));
            apple_eaten = ($urandom_range(0, 9) == 0);
            collision = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
